// File: rtl/wb_stage_dual_if.sv
// MEM->WB bus for the dual-lane writeback stage.
// Carries both lane captures in and the register-file write ports out.
interface wb_stage_dual_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic            stall_w;
    logic            flush_w;
    logic            valid_m;
    logic            valid_m_2;
    logic            regwrite_m;
    logic            regwrite_m_2;
    logic [4:0]      rd_m;
    logic [4:0]      rd_m_2;
    logic [1:0]      result_src_m;
    logic [1:0]      result_src_m_2;
    logic [2:0]      funct3_m;
    logic [2:0]      funct3_m_2;
    logic [XLEN-1:0] alu_result_m;
    logic [XLEN-1:0] alu_result_m_2;
    logic [XLEN-1:0] read_data_m;
    logic [XLEN-1:0] read_data_m_2;
    logic [XLEN-1:0] pc_plus4_m;
    logic [XLEN-1:0] pc_plus4_m_2;
    logic [XLEN-1:0] imm_ext_m;
    logic [XLEN-1:0] imm_ext_m_2;
    logic            order_change_m;
    logic [4:0]      A3;
    logic [4:0]      A3_2;
    logic            WE3;
    logic            WE3_2;
    logic [XLEN-1:0] WD3;
    logic [XLEN-1:0] WD3_2;
    logic            order_change_w;
    logic [CNT_W-1:0] instret;

    modport slave (
        input  stall_w, flush_w,
        input  valid_m, valid_m_2,
        input  regwrite_m, regwrite_m_2,
        input  rd_m, rd_m_2,
        input  result_src_m, result_src_m_2,
        input  funct3_m, funct3_m_2,
        input  alu_result_m, alu_result_m_2,
        input  read_data_m, read_data_m_2,
        input  pc_plus4_m, pc_plus4_m_2,
        input  imm_ext_m, imm_ext_m_2,
        input  order_change_m,
        output A3, A3_2, WE3, WE3_2,
        output WD3, WD3_2,
        output order_change_w, instret
    );

    modport master (
        output stall_w, flush_w,
        output valid_m, valid_m_2,
        output regwrite_m, regwrite_m_2,
        output rd_m, rd_m_2,
        output result_src_m, result_src_m_2,
        output funct3_m, funct3_m_2,
        output alu_result_m, alu_result_m_2,
        output read_data_m, read_data_m_2,
        output pc_plus4_m, pc_plus4_m_2,
        output imm_ext_m, imm_ext_m_2,
        output order_change_m,
        input  A3, A3_2, WE3, WE3_2,
        input  WD3, WD3_2,
        input  order_change_w, instret
    );
endinterface

// File: rtl/wb_stage_dual.sv
// Dual-lane MEM->WB register with load formatting and
// in-order same-rd resolution. Optional: WB_INSTRET_EN.
module wb_stage_dual #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input logic           clk,
    input logic           reset,
    wb_stage_dual_if.slave bus
);

    function automatic logic [XLEN-1:0] fmt_load(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] data
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [XLEN-1:0] r;
        case (off)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = off[1] ? data[31:16] : data[15:0];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] sel_res(
        input logic [1:0]      src,
        input logic [2:0]      f3,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] rdata,
        input logic [XLEN-1:0] pc4,
        input logic [XLEN-1:0] imm
    );
        logic [XLEN-1:0] r;
        case (src)
            2'b00:   r = alu;
            2'b01:   r = fmt_load(f3, alu[1:0], rdata);
            2'b10:   r = pc4;
            default: r = imm;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0] res_1;
    logic [XLEN-1:0] res_2;

    logic            valid_q;
    logic            valid_q_2;
    logic            rw_q;
    logic            rw_q_2;
    logic [4:0]      rd_q;
    logic [4:0]      rd_q_2;
    logic [XLEN-1:0] wd_q;
    logic [XLEN-1:0] wd_q_2;
    logic            oc_q;

    logic            we_base;
    logic            we_base_2;
    logic            coll;

    // Result selection ahead of the register so WD is stable all cycle
    always_comb begin
        res_1 = sel_res(bus.result_src_m, bus.funct3_m,
                        bus.alu_result_m, bus.read_data_m,
                        bus.pc_plus4_m, bus.imm_ext_m);
        res_2 = sel_res(bus.result_src_m_2, bus.funct3_m_2,
                        bus.alu_result_m_2, bus.read_data_m_2,
                        bus.pc_plus4_m_2, bus.imm_ext_m_2);
    end

    // WB pipeline register: flush beats stall beats capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            valid_q_2 <= 1'b0;
            rw_q      <= 1'b0;
            rw_q_2    <= 1'b0;
            rd_q      <= '0;
            rd_q_2    <= '0;
            wd_q      <= '0;
            wd_q_2    <= '0;
            oc_q      <= 1'b0;
        end else if (bus.flush_w) begin
            valid_q   <= 1'b0;
            valid_q_2 <= 1'b0;
            rw_q      <= 1'b0;
            rw_q_2    <= 1'b0;
            rd_q      <= '0;
            rd_q_2    <= '0;
            wd_q      <= '0;
            wd_q_2    <= '0;
            oc_q      <= 1'b0;
        end else if (!bus.stall_w) begin
            valid_q   <= bus.valid_m;
            valid_q_2 <= bus.valid_m_2;
            rw_q      <= bus.regwrite_m;
            rw_q_2    <= bus.regwrite_m_2;
            rd_q      <= bus.rd_m;
            rd_q_2    <= bus.rd_m_2;
            wd_q      <= res_1;
            wd_q_2    <= res_2;
            oc_q      <= bus.order_change_m;
        end
    end

    // Same-rd collision: the older lane is suppressed
    always_comb begin
        we_base   = valid_q & rw_q & (|rd_q);
        we_base_2 = valid_q_2 & rw_q_2 & (|rd_q_2);
        coll      = we_base & we_base_2 & (rd_q == rd_q_2);
    end

    assign bus.WE3            = we_base & ~(coll & ~oc_q);
    assign bus.WE3_2          = we_base_2 & ~(coll & oc_q);
    assign bus.A3             = rd_q;
    assign bus.A3_2           = rd_q_2;
    assign bus.WD3            = wd_q;
    assign bus.WD3_2          = wd_q_2;
    assign bus.order_change_w = oc_q;

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] cnt_q;

    // Retire counter: adds lanes leaving WB, held while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (!bus.stall_w)
            cnt_q <= cnt_q
                   + {{(CNT_W-1){1'b0}}, valid_q}
                   + {{(CNT_W-1){1'b0}}, valid_q_2};
    end

    assign bus.instret = cnt_q;
`else
    assign bus.instret = '0;
`endif

endmodule
